// File: rtl/audio_pkg.sv
// Shared types and constants for the audio vector streamer.
// State encoding plus vector/sample geometry.
package audio_pkg;

  localparam int SAMPLES_PER_WORD = 16;
  localparam int SAMPLE_W         = 8;
  localparam int VEC_W            = 128;
  localparam int IDX_W            = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_FINISH
  } state_e;

endpackage

// File: rtl/vec_byte_serializer.sv
// Current/shadow 128-bit word registers with a byte index.
// Bytes leave LSB first; a write lands in current if it is empty.
module vec_byte_serializer
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [VEC_W-1:0]    wr_data,
  input  logic                advance,
  output logic                cur_valid,
  output logic                sh_valid,
  output logic                last_byte,
  output logic [SAMPLE_W-1:0] byte_out
);

  logic [VEC_W-1:0] cur_q, cur_d;
  logic [VEC_W-1:0] sh_q, sh_d;
  logic             cur_v_q, cur_v_d;
  logic             sh_v_q, sh_v_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign cur_valid = cur_v_q;
  assign sh_valid  = sh_v_q;
  assign last_byte = idx_q == IDX_W'(SAMPLES_PER_WORD - 1);
  assign byte_out  = cur_q[{idx_q, 3'b000} +: SAMPLE_W];

  // Advance/promote, then place incoming word; flush wins.
  always_comb begin
    cur_d   = cur_q;
    sh_d    = sh_q;
    cur_v_d = cur_v_q;
    sh_v_d  = sh_v_q;
    idx_d   = idx_q;
    if (advance) begin
      if (last_byte) begin
        idx_d   = '0;
        cur_v_d = sh_v_q;
        sh_v_d  = 1'b0;
        if (sh_v_q) cur_d = sh_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (wr_en) begin
      if (!cur_v_d) begin
        cur_d   = wr_data;
        cur_v_d = 1'b1;
        idx_d   = '0;
      end else begin
        sh_d   = wr_data;
        sh_v_d = 1'b1;
      end
    end
    if (flush) begin
      cur_v_d = 1'b0;
      sh_v_d  = 1'b0;
      idx_d   = '0;
    end
  end

  // Word register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q   <= '0;
      sh_q    <= '0;
      cur_v_q <= 1'b0;
      sh_v_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      cur_q   <= cur_d;
      sh_q    <= sh_d;
      cur_v_q <= cur_v_d;
      sh_v_q  <= sh_v_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/audio_stream_out.sv
// Streams 128-bit memory words out as 8-bit samples on sample_tick.
// AUDIO_STREAM_LOOP_EN: wrap to base_addr after the last word forever.
module audio_stream_out
  import audio_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   num_words,
  input  logic                sample_tick,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [VEC_W-1:0]    mem_q,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LAT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   num_q, num_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   issued_q, issued_d;
  logic                rd_busy_q, rd_busy_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                sample_valid_q, sample_valid_d;
  logic                underrun_q, underrun_d;
`ifdef AUDIO_STREAM_LOOP_EN
  logic [ADDR_W-1:0]   base_q, base_d;
`else
  logic [ADDR_W-1:0]   words_out_q, words_out_d;
`endif

  logic                rd_ret, emit, flush, issue, restart;
  logic [ADDR_W-1:0]   issue_addr;
  logic                cur_valid, sh_valid, last_byte;
  logic [SAMPLE_W-1:0] ser_byte;

  assign mem_addr     = mem_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_FINISH;
  assign underrun     = underrun_q;

  vec_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (rd_ret),
    .wr_data   (mem_q),
    .advance   (emit),
    .cur_valid (cur_valid),
    .sh_valid  (sh_valid),
    .last_byte (last_byte),
    .byte_out  (ser_byte)
  );

  // Next-state, read issue/return tracking and sample output.
  always_comb begin
    state_d        = state_q;
    num_d          = num_q;
    addr_d         = addr_q;
    mem_addr_d     = mem_addr_q;
    issued_d       = issued_q;
    rd_busy_d      = rd_busy_q;
    rd_cnt_d       = rd_cnt_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    underrun_d     = underrun_q;
`ifdef AUDIO_STREAM_LOOP_EN
    base_d         = base_q;
`else
    words_out_d    = words_out_q;
`endif
    flush      = 1'b0;
    issue      = 1'b0;
    restart    = 1'b0;
    issue_addr = addr_q;

    rd_ret = rd_busy_q && (rd_cnt_q == LAT);
    emit   = !abort && (state_q == S_STREAM)
             && sample_tick && cur_valid;

    if (rd_busy_q) begin
      if (rd_ret) rd_busy_d = 1'b0;
      else        rd_cnt_d  = rd_cnt_q + 1'b1;
    end

    if (emit) begin
      sample_out_d   = ser_byte;
      sample_valid_d = 1'b1;
    end

    if (!abort && sample_tick && !cur_valid
        && (state_q == S_FETCH || state_q == S_WAIT
            || state_q == S_STREAM))
      underrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          num_d      = num_words;
          underrun_d = 1'b0;
          flush      = 1'b1;
`ifdef AUDIO_STREAM_LOOP_EN
          base_d     = base_addr;
`else
          words_out_d = '0;
`endif
          if (num_words == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d    = S_FETCH;
            issue      = 1'b1;
            restart    = 1'b1;
            issue_addr = base_addr;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (rd_ret) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!rd_busy_q && !sh_valid) begin
`ifdef AUDIO_STREAM_LOOP_EN
          issue = 1'b1;
          if (issued_q == num_q) begin
            restart    = 1'b1;
            issue_addr = base_q;
          end
`else
          issue = issued_q != num_q;
`endif
        end
`ifndef AUDIO_STREAM_LOOP_EN
        if (emit && last_byte) begin
          if (words_out_q == num_q - 1'b1)
            state_d = S_FINISH;
          else
            words_out_d = words_out_q + 1'b1;
        end
`endif
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (issue && !abort) begin
      mem_addr_d = issue_addr;
      addr_d     = issue_addr + 1'b1;
      issued_d   = restart ? ADDR_W'(1) : issued_q + 1'b1;
      rd_busy_d  = 1'b1;
      rd_cnt_d   = '0;
    end

    if (abort) begin
      state_d   = S_IDLE;
      rd_busy_d = 1'b0;
      flush     = 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      num_q          <= '0;
      addr_q         <= '0;
      mem_addr_q     <= '0;
      issued_q       <= '0;
      rd_busy_q      <= 1'b0;
      rd_cnt_q       <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
`ifdef AUDIO_STREAM_LOOP_EN
      base_q         <= '0;
`else
      words_out_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      num_q          <= num_d;
      addr_q         <= addr_d;
      mem_addr_q     <= mem_addr_d;
      issued_q       <= issued_d;
      rd_busy_q      <= rd_busy_d;
      rd_cnt_q       <= rd_cnt_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
`ifdef AUDIO_STREAM_LOOP_EN
      base_q         <= base_d;
`else
      words_out_q    <= words_out_d;
`endif
    end
  end

endmodule

// File: doc/audio_stream_out.md
AUDIO_STREAM_OUT -- requirements
Module: audio_stream_out

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning word-address width of the vector (128-bit) data-memory port.
REQ-002 SHALL have parameter READ_LAT, default 1, meaning clocks from mem_addr change to valid mem_q.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle request to begin streaming; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, meaning terminate streaming and return to IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_W, meaning first vector word address.
REQ-008 SHALL have port num_words, input, ADDR_W, meaning vector word count; 0 is legal.
REQ-009 SHALL have port sample_tick, input, 1, meaning a one-cycle audio-rate strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W, meaning the read address to the vector memory port.
REQ-011 SHALL have port mem_q, input, 128, meaning the read data from the vector memory port.
REQ-012 SHALL have port sample_out, output, 8, meaning the current signed 8-bit sample.
REQ-013 SHALL have port sample_valid, output, 1, meaning a one-cycle pulse when sample_out updates.
REQ-014 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1, meaning a one-cycle pulse at normal completion.
REQ-016 SHALL have port underrun, output, 1, meaning a sticky flag for a tick with no data ready.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, STREAM, FINISH.
REQ-018 In IDLE, start SHALL latch base_addr and num_words; next state FETCH, or FINISH if num_words==0.
REQ-019 In FETCH, the block SHALL drive mem_addr = current word address for one cycle, then go to WAIT.
REQ-020 WAIT SHALL last READ_LAT cycles; mem_q SHALL then be captured into the current-word register, and the next state SHALL be STREAM.
REQ-021 In STREAM, each sample_tick SHALL emit byte[idx] of the current word (bits 8*idx+7:8*idx, idx 0..15, byte 0 first) on sample_out, with sample_valid asserted the following cycle.
REQ-022 While the current word is held, the block SHALL prefetch the next word into a shadow register (at most one outstanding read).
REQ-023 After byte 15 is emitted, the shadow word SHALL become current in the same cycle if it is valid; otherwise the block SHALL wait in STREAM with current empty.
REQ-024 A sample_tick while current is empty SHALL set underrun, emit nothing, and leave sample_out unchanged.
REQ-025 After byte 15 of word num_words-1, the next state SHALL be FINISH; FINISH SHALL pulse done for one cycle and then return to IDLE.
REQ-026 The word address SHALL increment modulo 2^ADDR_W (wraps to 0 past the maximum).
REQ-027 start while busy SHALL be ignored; abort SHALL have priority over start and tick, SHALL force IDLE next cycle, SHALL cancel the pending prefetch, and SHALL NOT pulse done.
REQ-028 underrun SHALL clear only on reset or on an accepted start.

Reset
REQ-029 Reset SHALL force IDLE, sample_out=0, sample_valid=0, busy=0, done=0, underrun=0, mem_addr=0, and invalidate both word registers, including when reset occurs mid-stream.

Configuration
REQ-030 With AUDIO_STREAM_LOOP_EN defined, the block SHALL return to base_addr after the last word instead of entering FINISH, and only abort or reset SHALL end streaming.
REQ-031 Without AUDIO_STREAM_LOOP_EN defined, the block SHALL behave as REQ-025, and no loop logic SHALL be synthesised.

Structure
REQ-032 A shared package audio_pkg SHALL hold the FSM state enum, SAMPLES_PER_WORD=16, SAMPLE_W=8, and VEC_W=128.
REQ-033 A sub-module vec_byte_serializer SHALL hold the current/shadow registers and byte index; the FSM and addressing SHALL stay in audio_stream_out.

Verification
REQ-034 Scenario: base_addr=0x10, num_words=2, words 0x0F..00 and 0x1F..10, ticks every 4 clocks -> samples 0x00..0x1F in order, done pulses once after the 32nd sample.
REQ-035 Scenario: num_words=0, start -> no sample_valid, done pulses within 2 cycles, busy returns to 0.
REQ-036 Scenario: ticks on consecutive clocks with READ_LAT=2 -> underrun=1 and no duplicated or skipped bytes; underrun clears on the next start.
REQ-037 Scenario: abort asserted after sample 5 -> IDLE next cycle, no done, and a following start restarts at base_addr.
REQ-038 Scenario: reset asserted mid-word, and base_addr=0x7FFF with num_words=2 -> all outputs reset; the second word is read from address 0x0000.
REQ-039 Scenario: with AUDIO_STREAM_LOOP_EN, num_words=1 for 40 ticks -> bytes 0..15 repeat cyclically and done never pulses.
